// File: rtl/hazard_unit.sv
// hazard_unit: load-use hazard detection and taken-branch flush control for a
// five-stage pipeline. Stall/flush outputs are combinational from the FSM state
// and the current inputs. Two saturating counters track bubble cycles and flushes.
//
// Pipeline-control handshake: pc_write and ifid_write act as "ready" signals
// toward the front end. Whenever either one is 0, that stage holds its contents
// for the cycle. ctrl_src=1 tells the control unit to inject a bubble into ID/EX.
// ifid_flush=1 clears IF/ID to a NOP in the same cycle.
module hazard_unit #(
    parameter int LOAD_STALL_CYCLES = 1,  // bubbles per load-use hazard, 1..7
    parameter int CNT_W             = 16  // statistics counter width
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       ifid_opcode,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             ex_branch_taken,
    input  logic             clr_cnt,
    output logic             ctrl_src,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [3:0]       dbg_state   // {in_stall, rem}
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Bubbles still owed once the first one has been inserted from RUN.
    localparam logic [2:0]       REM_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic use_rs1;
    logic use_rs2;
    logic hazard;

    // Decode which source registers the ID instruction actually reads.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (ifid_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // x0 never carries a real dependency, so a load to x0 cannot cause a hazard.
    assign hazard = idex_memread && (idex_rd != 5'd0) &&
                    ((use_rs1 && (ifid_rs1 == idex_rd)) ||
                     (use_rs2 && (ifid_rs2 == idex_rd)));

    // Pipeline control outputs; reset forces the free-running defaults.
    always_comb begin
        ctrl_src   = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        if (!reset_n) begin
            ctrl_src   = 1'b0;
        end else if (ex_branch_taken) begin
            ctrl_src   = 1'b1;
            pc_write   = 1'b1;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end else if (state_q == STALL || hazard) begin
            ctrl_src   = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    // Next FSM state; a taken branch wins, and STALL ignores the hazard inputs.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (ex_branch_taken) begin
            state_d = RUN;
            rem_d   = 3'd0;
        end else if (state_q == STALL) begin
            rem_d = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (hazard && LOAD_STALL_CYCLES > 1) begin
            state_d = STALL;
            rem_d   = REM_INIT;
        end
    end

    // Next counter values: clear overrides, otherwise saturating increments.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (ctrl_src && !ex_branch_taken && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (ex_branch_taken && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // FSM state register; reset aborts any stall in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign dbg_state = {state_q == STALL, rem_q};

endmodule
